// File: rtl/wb_arb.sv
// wb_arb: merges ALU, LSU and CSR writebacks into one shared
// in-order queue that drains into the single register-file port.
module wb_arb #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_wb_vld,
  input  logic [4:0]  alu_wb_addr,
  input  logic [63:0] alu_wb_data,
  output logic        alu_wb_rdy,
  input  logic        lsu_wb_vld,
  input  logic [4:0]  lsu_wb_addr,
  input  logic [63:0] lsu_wb_data,
  output logic        lsu_wb_rdy,
  input  logic        csr_wb_vld,
  input  logic [4:0]  csr_wb_addr,
  input  logic [63:0] csr_wb_data,
  output logic        csr_wb_rdy,
  output logic        wb_vld,
  output logic [4:0]  wb_addr,
  output logic [63:0] wb_data,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_pend,
  output logic        rs2_pend
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW+1:0] DEP = (PW+2)'(DEPTH);

  logic [CW-1:0]    count;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [4:0]       ent_addr [DEPTH];
  logic [63:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0] vld_nxt;

  logic             pop;
  logic [4:0]       free;
  logic             alu_en;
  logic             lsu_en;
  logic             csr_en;
  logic [1:0]       n_enq;
  logic [PW-1:0]    slot_l;
  logic [PW-1:0]    slot_c;
  logic [PW-1:0]    tail_nxt;
  logic [PW-1:0]    head_nxt;
  logic             hit1;
  logic             hit2;

  // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input logic [1:0]    k
  );
    logic [PW+1:0] s;
    s = (PW+2)'(p) + (PW+2)'(k);
    if (s >= DEP) s = s - DEP;
    if (s >= DEP) s = s - DEP;
    return s[PW-1:0];
  endfunction

  // Head pops every cycle it is valid, so its slot is free
  // for the same cycle's enqueues.
  always_comb begin
    pop        = (count != '0);
    free       = 5'(DEPTH) - 5'(count) + 5'(pop);
    alu_wb_rdy = (free >= 5'd1);
    lsu_wb_rdy = (free >= 5'd1 + 5'(alu_wb_vld));
    csr_wb_rdy = (free >= 5'd1 + 5'(alu_wb_vld)
                         + 5'(lsu_wb_vld));
  end

  // Accepted writes to x0 are acked but never take a slot.
  always_comb begin
    alu_en   = alu_wb_vld & alu_wb_rdy & (alu_wb_addr != 5'd0);
    lsu_en   = lsu_wb_vld & lsu_wb_rdy & (lsu_wb_addr != 5'd0);
    csr_en   = csr_wb_vld & csr_wb_rdy & (csr_wb_addr != 5'd0);
    n_enq    = 2'(alu_en) + 2'(lsu_en) + 2'(csr_en);
    slot_l   = wrap(tail, 2'(alu_en));
    slot_c   = wrap(tail, 2'(alu_en) + 2'(lsu_en));
    tail_nxt = wrap(tail, n_enq);
    head_nxt = wrap(head, 2'(pop));
  end

  // Per-slot valid: clear the popped head, then mark new tails.
  always_comb begin
    vld_nxt = ent_vld;
    if (pop)    vld_nxt[head]   = 1'b0;
    if (alu_en) vld_nxt[tail]   = 1'b1;
    if (lsu_en) vld_nxt[slot_l] = 1'b1;
    if (csr_en) vld_nxt[slot_c] = 1'b1;
  end

  // Queue control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      head    <= '0;
      tail    <= '0;
      ent_vld <= '0;
    end else begin
      count   <= count + CW'(n_enq) - CW'(pop);
      head    <= head_nxt;
      tail    <= tail_nxt;
      ent_vld <= vld_nxt;
    end
  end

  // Entry payload storage, written in ALU, LSU, CSR order.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (alu_en) begin
        ent_addr[tail] <= alu_wb_addr;
        ent_data[tail] <= alu_wb_data;
      end
      if (lsu_en) begin
        ent_addr[slot_l] <= lsu_wb_addr;
        ent_data[slot_l] <= lsu_wb_data;
      end
      if (csr_en) begin
        ent_addr[slot_c] <= csr_wb_addr;
        ent_data[slot_c] <= csr_wb_data;
      end
    end
  end

  // Head drives the register-file port; zeros when empty.
  always_comb begin
    wb_vld  = rst_n & pop;
    wb_addr = wb_vld ? ent_addr[head] : 5'd0;
    wb_data = wb_vld ? ent_data[head] : 64'd0;
  end

  // Scoreboard hazard lookup over queued entries only.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && ent_addr[i] == rs1) hit1 = 1'b1;
      if (ent_vld[i] && ent_addr[i] == rs2) hit2 = 1'b1;
    end
    rs1_pend = rst_n & (rs1 != 5'd0) & hit1;
    rs2_pend = rst_n & (rs2 != 5'd0) & hit2;
  end

endmodule

// File: tb/tb_wb_arb.sv
// tb_wb_arb: directed stimulus with a due-cycle scoreboard
// checked by an independent writeback monitor.
module tb_wb_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_wb_vld, lsu_wb_vld, csr_wb_vld;
  logic [4:0]  alu_wb_addr, lsu_wb_addr, csr_wb_addr;
  logic [63:0] alu_wb_data, lsu_wb_data, csr_wb_data;
  logic        alu_wb_rdy, lsu_wb_rdy, csr_wb_rdy;
  logic        wb_vld;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic [4:0]  rs1, rs2;
  logic        rs1_pend, rs2_pend;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
    int          due;
  } ent_t;

  ent_t sb[$];
  int   cyc = 0;
  int   last_due = 0;
  int   total = 0;
  int   bad = 0;

  wb_arb #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wb_vld(alu_wb_vld), .alu_wb_addr(alu_wb_addr),
    .alu_wb_data(alu_wb_data), .alu_wb_rdy(alu_wb_rdy),
    .lsu_wb_vld(lsu_wb_vld), .lsu_wb_addr(lsu_wb_addr),
    .lsu_wb_data(lsu_wb_data), .lsu_wb_rdy(lsu_wb_rdy),
    .csr_wb_vld(csr_wb_vld), .csr_wb_addr(csr_wb_addr),
    .csr_wb_data(csr_wb_data), .csr_wb_rdy(csr_wb_rdy),
    .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data),
    .rs1(rs1), .rs2(rs2),
    .rs1_pend(rs1_pend), .rs2_pend(rs2_pend)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm,
                              input logic [71:0] act,
                              input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  function automatic void push(input logic [4:0] a,
                               input logic [63:0] d);
    ent_t e;
    e.a = a;
    e.d = d;
    e.due = (cyc + 1 > last_due + 1) ? cyc + 1 : last_due + 1;
    last_due = e.due;
    sb.push_back(e);
  endfunction

  // Monitor: every cycle, either the front entry is due or
  // the port must be idle with zeroed address and data.
  always @(negedge clk) begin
    ent_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("wb", {1'b1, wb_vld, 1'b0, wb_addr, wb_data},
          {1'b1, 1'b1, 1'b0, e.a, e.d});
    end else begin
      chk("wb_idle", {1'b1, wb_vld, 1'b0, wb_addr, wb_data},
          72'h80_0000_0000_0000_0000);
    end
  end

  task automatic step(
    input logic av, input logic [4:0] aa, input logic [63:0] ad,
    input logic lv, input logic [4:0] la, input logic [63:0] ld,
    input logic cv, input logic [4:0] ca, input logic [63:0] cd,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic [2:0] er, input logic [1:0] ep, input string nm
  );
    alu_wb_vld = av; alu_wb_addr = aa; alu_wb_data = ad;
    lsu_wb_vld = lv; lsu_wb_addr = la; lsu_wb_data = ld;
    csr_wb_vld = cv; csr_wb_addr = ca; csr_wb_data = cd;
    rs1 = r1;
    rs2 = r2;
    @(negedge clk);
    chk({nm, "_rdy"}, 72'({alu_wb_rdy, lsu_wb_rdy, csr_wb_rdy}),
        72'(er));
    chk({nm, "_pend"}, 72'({rs1_pend, rs2_pend}), 72'(ep));
    if (av && er[2] && aa != 5'd0) push(aa, ad);
    if (lv && er[1] && la != 5'd0) push(la, ld);
    if (cv && er[0] && ca != 5'd0) push(ca, cd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [1:0] ep,
                      input string nm);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2, 3'b111, ep, nm);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_wb_vld = 0; alu_wb_addr = 0; alu_wb_data = 0;
    lsu_wb_vld = 0; lsu_wb_addr = 0; lsu_wb_data = 0;
    csr_wb_vld = 0; csr_wb_addr = 0; csr_wb_data = 0;
    rs1 = 0;
    rs2 = 0;
    repeat (2) @(posedge clk);
    #1;
    rs1 = 5'd5;
    @(negedge clk);
    chk("rst_pend", 72'({rs1_pend, rs2_pend}), 72'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    idle(1, 0, 0, 2'b00, "reset_state");

    step(1, 5, 64'h11, 0, 0, 0, 0, 0, 0, 0, 0,
         3'b111, 2'b00, "single");
    idle(2, 0, 0, 2'b00, "single_drain");

    step(1, 1, 64'hA, 1, 2, 64'hB, 1, 3, 64'hC, 0, 0,
         3'b111, 2'b00, "triple");
    idle(4, 0, 0, 2'b00, "triple_drain");

    step(1, 4, 64'h40, 1, 5, 64'h50, 1, 6, 64'h60, 0, 0,
         3'b111, 2'b00, "bp_fill");
    step(1, 8, 64'h80, 1, 9, 64'h90, 0, 0, 0, 0, 0,
         3'b110, 2'b00, "bp_cnt3");
    step(1, 10, 64'hA0, 1, 11, 64'hB0, 0, 0, 0, 0, 0,
         3'b100, 2'b00, "bp_full");
    step(0, 0, 0, 1, 11, 64'hB0, 0, 0, 0, 0, 0,
         3'b110, 2'b00, "bp_retry");
    idle(5, 0, 0, 2'b00, "bp_drain");

    step(0, 0, 0, 1, 0, 64'hDEAD, 0, 0, 0, 0, 0,
         3'b111, 2'b00, "x0_lsu");
    idle(2, 0, 0, 2'b00, "x0_quiet");

    step(1, 14, 64'hE0, 1, 15, 64'hF0, 1, 16, 64'h100, 0, 0,
         3'b111, 2'b00, "x0_fill");
    step(1, 0, 64'h5, 1, 17, 64'h110, 1, 18, 64'h120, 0, 0,
         3'b110, 2'b00, "x0_thresh");
    step(0, 0, 0, 0, 0, 0, 1, 18, 64'h120, 0, 0,
         3'b111, 2'b00, "x0_retry");
    idle(5, 0, 0, 2'b00, "x0_drain");

    step(1, 7, 64'h77, 0, 0, 0, 0, 0, 0, 7, 0,
         3'b111, 2'b00, "pend_push");
    idle(1, 7, 0, 2'b10, "pend_hit");
    idle(1, 7, 0, 2'b00, "pend_gone");

    step(1, 7, 64'h71, 1, 9, 64'h91, 0, 0, 0, 7, 9,
         3'b111, 2'b00, "pend2_push");
    idle(1, 7, 9, 2'b11, "pend2_both");
    idle(1, 7, 9, 2'b01, "pend2_rs2");
    idle(1, 7, 9, 2'b00, "pend2_none");

    step(1, 20, 64'h200, 1, 21, 64'h210, 1, 22, 64'h220, 0, 0,
         3'b111, 2'b00, "rst_fill");
    rst_n = 1'b0;
    alu_wb_vld = 1; alu_wb_addr = 23; alu_wb_data = 64'h230;
    lsu_wb_vld = 0;
    csr_wb_vld = 0;
    rs1 = 21;
    rs2 = 22;
    sb.delete();
    last_due = 0;
    @(negedge clk);
    chk("rst_mid_pend", 72'({rs1_pend, rs2_pend}), 72'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2, 21, 23, 2'b00, "rst_after");

    step(1, 24, 64'h240, 0, 0, 0, 0, 0, 0, 24, 0,
         3'b111, 2'b00, "post_rst");
    idle(1, 24, 0, 2'b10, "post_rst_hit");
    idle(2, 24, 0, 2'b00, "post_rst_drain");

    chk("sb_empty", 72'(sb.size()), 72'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
